// File: rtl/bebidas_pkg.sv
// Shared types and constants for the coffee vending sequencer.
// Holds the FSM states, coin and selection codes, recipe masks and the stage-order helpers.
package bebidas_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AGUA   = 3'd1,
        CAFE   = 3'd2,
        LECHE  = 3'd3,
        CAMBIO = 3'd4,
        FIN    = 3'd5
    } estado_t;

    localparam logic [1:0] MONEDA_100 = 2'b01;
    localparam logic [1:0] MONEDA_500 = 2'b10;

    localparam logic [2:0] SEL_NINGUNA  = 3'b000;
    localparam logic [2:0] SEL_BEBIDA_1 = 3'b001;
    localparam logic [2:0] SEL_BEBIDA_2 = 3'b010;
    localparam logic [2:0] SEL_BEBIDA_3 = 3'b011;
    localparam logic [2:0] SEL_BEBIDA_4 = 3'b100;

    // Recipe masks are {agua, cafe, leche}
    localparam logic [2:0] RECETA_1 = 3'b110;
    localparam logic [2:0] RECETA_2 = 3'b110;
    localparam logic [2:0] RECETA_3 = 3'b111;
    localparam logic [2:0] RECETA_4 = 3'b111;

    function automatic logic sel_valida(input logic [2:0] s);
        return (s >= SEL_BEBIDA_1) && (s <= SEL_BEBIDA_4);
    endfunction

    function automatic logic [2:0] receta_de(input logic [2:0] s);
        case (s)
            SEL_BEBIDA_1: return RECETA_1;
            SEL_BEBIDA_2: return RECETA_2;
            SEL_BEBIDA_3: return RECETA_3;
            SEL_BEBIDA_4: return RECETA_4;
            default:      return 3'b000;
        endcase
    endfunction

    // Next enabled stage after 'actual', walking water -> coffee -> milk, then change
    function automatic estado_t siguiente_etapa(input logic [2:0] receta, input estado_t actual);
        if (actual == IDLE && receta[2]) begin
            return AGUA;
        end else if ((actual == IDLE || actual == AGUA) && receta[1]) begin
            return CAFE;
        end else if ((actual == IDLE || actual == AGUA || actual == CAFE) && receta[0]) begin
            return LECHE;
        end
        return CAMBIO;
    endfunction

endpackage

// File: rtl/temporizador_etapa.sv
// Loadable down-counter shared by all preparation stages.
// done_c is high while the count sits at zero; load takes priority over counting.
module temporizador_etapa #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_c
);

    logic [W-1:0] cuenta_q;
    logic [W-1:0] cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (load_i) begin
            cuenta_d = value_i;
        end else if (cuenta_q != '0) begin
            cuenta_d = cuenta_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign done_c = (cuenta_q == '0);

endmodule

// File: rtl/controlador_bebidas.sv
// Coffee vending sequencer: credit accumulation, drink validation, timed actuator
// stages and change return in 100-unit pulses.
module controlador_bebidas
    import bebidas_pkg::*;
#(
    parameter int unsigned PRECIO_1 = 300,
    parameter int unsigned PRECIO_2 = 500,
    parameter int unsigned PRECIO_3 = 600,
    parameter int unsigned PRECIO_4 = 800,
    parameter int unsigned CRED_MAX = 2000,
    parameter int unsigned T_AGUA   = 8,
    parameter int unsigned T_CAFE   = 5,
    parameter int unsigned T_LECHE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  moneda,
    input  logic [2:0]  sel,
    input  logic        cancelar,
    output logic [11:0] credito,
    output logic        valvula_agua,
    output logic        molino_cafe,
    output logic        valvula_leche,
    output logic        cambio100,
    output logic        rechazo,
    output logic        error_saldo,
    output logic        ocupado,
    output logic        listo
);

    localparam int unsigned CW = 12;
    localparam int unsigned TW = 8;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] credito_q, credito_d;
    logic [2:0]    bebida_q, bebida_d;
    logic          prepara_q, prepara_d;
    logic          agua_q, cafe_q, leche_q, cambio_q, rechazo_q, error_q, ocupado_q, listo_q;
    logic          cambio_d, rechazo_d, error_d;

    logic [CW-1:0] moneda_val;
    logic          moneda_hay;
    logic [CW:0]   suma;
    logic          carga;
    logic [TW-1:0] valor_carga;
    logic          etapa_fin;
    estado_t       siguiente;

    function automatic logic [CW-1:0] precio_de(input logic [2:0] s);
        case (s)
            SEL_BEBIDA_1: return CW'(PRECIO_1);
            SEL_BEBIDA_2: return CW'(PRECIO_2);
            SEL_BEBIDA_3: return CW'(PRECIO_3);
            SEL_BEBIDA_4: return CW'(PRECIO_4);
            default:      return '0;
        endcase
    endfunction

    // Counter reload value: stage length minus one, doubled water for drink 2, doubled coffee for drink 4
    function automatic logic [TW-1:0] duracion(input estado_t e, input logic [2:0] s);
        case (e)
            AGUA:    return (s == SEL_BEBIDA_2) ? TW'(2 * T_AGUA - 1) : TW'(T_AGUA - 1);
            CAFE:    return (s == SEL_BEBIDA_4) ? TW'(2 * T_CAFE - 1) : TW'(T_CAFE - 1);
            LECHE:   return TW'(T_LECHE - 1);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        case (moneda)
            MONEDA_100: moneda_val = CW'(100);
            MONEDA_500: moneda_val = CW'(500);
            default:    moneda_val = '0;
        endcase
    end

    assign moneda_hay = (moneda_val != '0);
    assign suma       = {1'b0, credito_q} + {1'b0, moneda_val};

    temporizador_etapa #(
        .W (TW)
    ) u_temporizador (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (carga),
        .value_i (valor_carga),
        .done_c  (etapa_fin)
    );

    // Next-state and datapath decisions; a coin is rejected unless IDLE accepts it
    always_comb begin
        estado_d    = estado_q;
        credito_d   = credito_q;
        bebida_d    = bebida_q;
        prepara_d   = prepara_q;
        cambio_d    = 1'b0;
        rechazo_d   = moneda_hay;
        error_d     = 1'b0;
        carga       = 1'b0;
        valor_carga = '0;
        siguiente   = CAMBIO;

        case (estado_q)
            IDLE: begin
                if (sel != SEL_NINGUNA) begin
                    if (!sel_valida(sel) || (credito_q < precio_de(sel))) begin
                        error_d = 1'b1;
                    end else begin
                        siguiente   = siguiente_etapa(receta_de(sel), IDLE);
                        credito_d   = credito_q - precio_de(sel);
                        bebida_d    = sel;
                        prepara_d   = 1'b1;
                        estado_d    = siguiente;
                        carga       = 1'b1;
                        valor_carga = duracion(siguiente, sel);
                    end
                end else if (cancelar) begin
                    if (credito_q != '0) begin
                        prepara_d = 1'b0;
                        estado_d  = CAMBIO;
                    end
                end else if (moneda_hay && (suma <= (CW + 1)'(CRED_MAX))) begin
                    credito_d = suma[CW-1:0];
                    rechazo_d = 1'b0;
                end
            end
            AGUA, CAFE, LECHE: begin
                if (etapa_fin) begin
                    siguiente   = siguiente_etapa(receta_de(bebida_q), estado_q);
                    estado_d    = siguiente;
                    carga       = 1'b1;
                    valor_carga = duracion(siguiente, bebida_q);
                end
            end
            CAMBIO: begin
                if (credito_q != '0) begin
                    credito_d = credito_q - CW'(100);
                    cambio_d  = 1'b1;
                end else begin
                    estado_d = FIN;
                end
            end
            FIN: begin
                prepara_d = 1'b0;
                estado_d  = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so each actuator tracks its stage cycle-for-cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q  <= IDLE;
            credito_q <= '0;
            bebida_q  <= SEL_NINGUNA;
            prepara_q <= 1'b0;
            agua_q    <= 1'b0;
            cafe_q    <= 1'b0;
            leche_q   <= 1'b0;
            cambio_q  <= 1'b0;
            rechazo_q <= 1'b0;
            error_q   <= 1'b0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            credito_q <= credito_d;
            bebida_q  <= bebida_d;
            prepara_q <= prepara_d;
            agua_q    <= (estado_d == AGUA);
            cafe_q    <= (estado_d == CAFE);
            leche_q   <= (estado_d == LECHE);
            cambio_q  <= cambio_d;
            rechazo_q <= rechazo_d;
            error_q   <= error_d;
            ocupado_q <= (estado_d != IDLE);
            listo_q   <= (estado_d == FIN) && prepara_q;
        end
    end

    assign credito       = credito_q;
    assign valvula_agua  = agua_q;
    assign molino_cafe   = cafe_q;
    assign valvula_leche = leche_q;
    assign cambio100     = cambio_q;
    assign rechazo       = rechazo_q;
    assign error_saldo   = error_q;
    assign ocupado       = ocupado_q;
    assign listo         = listo_q;

endmodule

// File: tb/tb_controlador_bebidas.sv
// Bench for controlador_bebidas: IDLE-phase vector table plus drink/refund/reset sequences
// with per-cycle expected outputs computed from the recipe timings.
module tb_controlador_bebidas;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  moneda;
    logic [2:0]  sel;
    logic        cancelar;
    logic [11:0] credito;
    logic        valvula_agua, molino_cafe, valvula_leche, cambio100;
    logic        rechazo, error_saldo, ocupado, listo;
    logic [7:0]  outs;

    int checks = 0;
    int errors = 0;

    // outs = {agua, cafe, leche, cambio100, rechazo, error_saldo, ocupado, listo}
    localparam logic [7:0] O_NADA = 8'h00;
    localparam logic [7:0] O_REJ  = 8'h08;
    localparam logic [7:0] O_ERR  = 8'h04;

    typedef struct {
        logic [1:0]  moneda;
        logic [2:0]  sel;
        logic        cancelar;
        logic [11:0] cred;
        logic [7:0]  outs;
    } vec_t;

    vec_t tabla [0:27];

    controlador_bebidas dut (
        .clk           (clk),
        .rst           (rst),
        .moneda        (moneda),
        .sel           (sel),
        .cancelar      (cancelar),
        .credito       (credito),
        .valvula_agua  (valvula_agua),
        .molino_cafe   (molino_cafe),
        .valvula_leche (valvula_leche),
        .cambio100     (cambio100),
        .rechazo       (rechazo),
        .error_saldo   (error_saldo),
        .ocupado       (ocupado),
        .listo         (listo)
    );

    assign outs = {valvula_agua, molino_cafe, valvula_leche, cambio100,
                   rechazo, error_saldo, ocupado, listo};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic comparar(input string nombre, input int idx,
                            input logic [7:0] want_o, input logic [11:0] want_c);
        checks++;
        if (outs !== want_o) begin
            errors++;
            $display("FAIL %s[%0d] outputs got %b want %b", nombre, idx, outs, want_o);
        end
        checks++;
        if (credito !== want_c) begin
            errors++;
            $display("FAIL %s[%0d] credito got %0d want %0d", nombre, idx, credito, want_c);
        end
    endtask

    task automatic aplicar(input logic [1:0] m, input logic [2:0] s, input logic c);
        moneda   = m;
        sel      = s;
        cancelar = c;
        tick();
        moneda   = 2'b00;
        sel      = 3'b000;
        cancelar = 1'b0;
    endtask

    task automatic correr_tabla(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            aplicar(tabla[i].moneda, tabla[i].sel, tabla[i].cancelar);
            comparar("vec", i, tabla[i].outs, tabla[i].cred);
        end
    endtask

    // Index 0 is the cycle right after the accepting edge; coin_at injects a coin after that index
    task automatic secuencia(input string nombre, input int na, input int nc, input int nl,
                             input int resto, input logic bebida, input int coin_at);
        int s, np, n;
        logic [7:0]  want_o;
        logic [11:0] want_c;
        s  = na + nc + nl;
        np = resto / 100;
        n  = s + np + 3;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                moneda = (i - 1 == coin_at) ? 2'b01 : 2'b00;
                tick();
                moneda = 2'b00;
            end
            want_o = O_NADA;
            want_c = 12'(resto);
            if (i < na) begin
                want_o[7] = 1'b1;
            end else if (i < na + nc) begin
                want_o[6] = 1'b1;
            end else if (i < s) begin
                want_o[5] = 1'b1;
            end else if (i > s && i <= s + np) begin
                want_o[4] = 1'b1;
                want_c    = 12'(resto - 100 * (i - s));
            end else if (i == s + np + 1) begin
                want_o[0] = bebida;
                want_c    = 12'd0;
            end else if (i == s + np + 2) begin
                want_c    = 12'd0;
            end
            if (i < s + np + 2) want_o[1] = 1'b1;
            if (i == coin_at + 1) want_o[3] = 1'b1;
            comparar(nombre, i, want_o, want_c);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tabla[0]  = '{2'b10, 3'b000, 1'b0, 12'd500,  O_NADA};
        tabla[1]  = '{2'b01, 3'b000, 1'b0, 12'd600,  O_NADA};
        tabla[2]  = '{2'b00, 3'b110, 1'b0, 12'd600,  O_ERR};
        tabla[3]  = '{2'b00, 3'b100, 1'b0, 12'd600,  O_ERR};
        tabla[4]  = '{2'b11, 3'b000, 1'b0, 12'd600,  O_NADA};
        tabla[5]  = '{2'b10, 3'b000, 1'b0, 12'd500,  O_NADA};
        tabla[6]  = '{2'b00, 3'b100, 1'b0, 12'd500,  O_ERR};
        tabla[7]  = '{2'b00, 3'b000, 1'b0, 12'd500,  O_NADA};
        tabla[8]  = '{2'b10, 3'b000, 1'b0, 12'd500,  O_NADA};
        tabla[9]  = '{2'b10, 3'b000, 1'b0, 12'd1000, O_NADA};
        tabla[10] = '{2'b10, 3'b000, 1'b0, 12'd500,  O_NADA};
        tabla[11] = '{2'b10, 3'b000, 1'b0, 12'd1000, O_NADA};
        tabla[12] = '{2'b10, 3'b000, 1'b0, 12'd1500, O_NADA};
        tabla[13] = '{2'b01, 3'b000, 1'b0, 12'd1600, O_NADA};
        tabla[14] = '{2'b01, 3'b000, 1'b0, 12'd1700, O_NADA};
        tabla[15] = '{2'b01, 3'b000, 1'b0, 12'd1800, O_NADA};
        tabla[16] = '{2'b01, 3'b000, 1'b0, 12'd1900, O_NADA};
        tabla[17] = '{2'b10, 3'b000, 1'b0, 12'd1900, O_REJ};
        tabla[18] = '{2'b01, 3'b000, 1'b0, 12'd2000, O_NADA};
        tabla[19] = '{2'b01, 3'b000, 1'b0, 12'd2000, O_REJ};
        tabla[20] = '{2'b01, 3'b101, 1'b0, 12'd2000, O_REJ | O_ERR};
        tabla[21] = '{2'b10, 3'b000, 1'b0, 12'd500,  O_NADA};
        tabla[22] = '{2'b01, 3'b000, 1'b0, 12'd600,  O_NADA};
        tabla[23] = '{2'b01, 3'b000, 1'b0, 12'd700,  O_NADA};
        tabla[24] = '{2'b01, 3'b000, 1'b0, 12'd800,  O_NADA};
        tabla[25] = '{2'b00, 3'b110, 1'b0, 12'd800,  O_ERR};
        tabla[26] = '{2'b00, 3'b000, 1'b1, 12'd0,    O_NADA};
        tabla[27] = '{2'b10, 3'b000, 1'b0, 12'd500,  O_NADA};

        rst      = 1'b0;
        moneda   = 2'b00;
        sel      = 3'b000;
        cancelar = 1'b0;
        #1;
        comparar("reset_async", 0, O_NADA, 12'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        comparar("reset_idle", 0, O_NADA, 12'd0);

        // Drink 3 with exact credit: water 8, coffee 5, milk 4, no change
        correr_tabla(0, 4);
        aplicar(2'b00, 3'b011, 1'b0);
        secuencia("bebida3", 8, 5, 4, 0, 1'b1, -2);

        // Insufficient credit, then a cancel-only refund of 500
        correr_tabla(5, 7);
        aplicar(2'b00, 3'b000, 1'b1);
        secuencia("cancelar", 0, 0, 0, 500, 1'b0, -2);

        // Drink 1 from 1000 leaves 700 to return
        correr_tabla(8, 9);
        aplicar(2'b00, 3'b001, 1'b0);
        secuencia("bebida1", 8, 5, 0, 700, 1'b1, -2);

        // Credit ceiling, then a coin during the grinder stage
        correr_tabla(10, 20);
        aplicar(2'b00, 3'b001, 1'b0);
        secuencia("moneda_en_cafe", 8, 5, 0, 1700, 1'b1, 9);

        // Selection beats a coincident coin; drink 2 has a doubled water stage
        correr_tabla(21, 25);
        aplicar(2'b01, 3'b010, 1'b0);
        secuencia("bebida2", 16, 5, 0, 300, 1'b1, -1);

        // Reset asserted mid-grinder clears everything without a clock edge
        correr_tabla(26, 27);
        aplicar(2'b00, 3'b001, 1'b0);
        repeat (9) tick();
        comparar("antes_reset", 0, 8'b0100_0010, 12'd200);
        #2;
        rst = 1'b0;
        #1;
        comparar("reset_en_cafe", 0, O_NADA, 12'd0);
        tick();
        comparar("reset_sostenido", 0, O_NADA, 12'd0);
        #3;
        rst = 1'b1;
        tick();
        comparar("tras_reset", 0, O_NADA, 12'd0);
        aplicar(2'b01, 3'b000, 1'b0);
        comparar("moneda_tras_reset", 0, O_NADA, 12'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
